// File: rtl/score_pkg.sv
// ============================================================================
// score_pkg : shared types and helpers for the BCD score keeper
// Revision  : 1.0
// ============================================================================
`default_nettype none

package score_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_NINE = 4'd9;

    // Packed BCD magnitude compare, most significant digit decides first.
    function automatic logic bcd_gt(input logic [31:0] a, input logic [31:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                gt      = (a[4*i +: 4] > b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_inc.sv
// ============================================================================
// bcd_digit_inc : single BCD digit incrementer with ripple carry out
// Revision      : 1.0
// ============================================================================
`default_nettype none

module bcd_digit_inc
    import score_pkg::*;
(
    input  logic digit_inc_dummy_unused_guard_n,
    input  bcd_t digit,
    input  logic inc_in,
    output bcd_t digit_next,
    output logic carry_out
);

    logic is_nine;

    assign is_nine    = (digit == BCD_NINE);
    assign carry_out  = inc_in & is_nine;
    assign digit_next = !inc_in ? digit : (is_nine ? 4'd0 : digit + 4'd1);

    logic unused_ok;
    assign unused_ok = digit_inc_dummy_unused_guard_n;

endmodule

`default_nettype wire

// File: rtl/score_keeper_bcd.sv
// ============================================================================
// score_keeper_bcd : packed-BCD game score counter with IDLE/RUN/OVER FSM.
// Optional high-score register enabled by defining SCORE_HISCORE_EN.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module score_keeper_bcd
    import score_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int TICKS_PER_POINT = 6
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                game_start,
    input  logic                game_over,
    input  logic                game_tick,
    output logic [4*DIGITS-1:0] score,
    output logic                running,
    output logic                saturated,
    output logic                milestone,
    output logic [4*DIGITS-1:0] hiscore,
    output logic                new_hiscore
);

    localparam int         SW         = 4 * DIGITS;
    localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_POINT - 1);

    state_t          state;
    state_t          state_next;
    logic            start_q;
    logic            over_q;
    logic            tick_q;
    logic            ev_start;
    logic            ev_over;
    logic            ev_tick;
    logic [7:0]      presc;
    logic            clear_game;
    logic            tick_run;
    logic            end_game;
    logic            point;
    logic [SW-1:0]   score_inc;
    logic [DIGITS:0] carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            over_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            start_q <= game_start;
            over_q  <= game_over;
            tick_q  <= game_tick;
        end
    end

    assign ev_start = game_start & ~start_q;
    assign ev_over  = game_over  & ~over_q;
    assign ev_tick  = game_tick  & ~tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Start beats over outside RUN; over beats tick inside RUN.
    always_comb begin
        state_next = state;
        clear_game = 1'b0;
        tick_run   = 1'b0;
        end_game   = 1'b0;
        case (state)
            S_IDLE, S_OVER: begin
                if (ev_start) begin
                    clear_game = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (ev_over) begin
                    end_game   = 1'b1;
                    state_next = S_OVER;
                end else if (ev_tick) begin
                    tick_run = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign point = tick_run && (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          presc <= 8'd0;
        else if (clear_game) presc <= 8'd0;
        else if (tick_run)   presc <= point ? 8'd0 : presc + 8'd1;
    end

    assign carry[0] = 1'b1;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            bcd_digit_inc u_digit (
                .digit_inc_dummy_unused_guard_n (1'b0),
                .digit      (score[4*i +: 4]),
                .inc_in     (carry[i]),
                .digit_next (score_inc[4*i +: 4]),
                .carry_out  (carry[i+1])
            );
        end
    endgenerate

    // With the chain always incrementing, a carry out of the top means all 9s.
    assign saturated = carry[DIGITS];
    assign running   = (state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score     <= '0;
            milestone <= 1'b0;
        end else begin
            milestone <= 1'b0;
            if (clear_game) begin
                score <= '0;
            end else if (point && !saturated) begin
                score     <= score_inc;
                milestone <= carry[2];
            end
        end
    end

`ifdef SCORE_HISCORE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hiscore     <= '0;
            new_hiscore <= 1'b0;
        end else if (clear_game) begin
            new_hiscore <= 1'b0;
        end else if (end_game) begin
            if (bcd_gt(32'(score), 32'(hiscore))) begin
                hiscore     <= score;
                new_hiscore <= 1'b1;
            end else begin
                new_hiscore <= 1'b0;
            end
        end
    end
`else
    logic unused_end_game;
    assign unused_end_game = end_game;
    assign hiscore         = '0;
    assign new_hiscore     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_score_keeper_bcd.sv
// ============================================================================
// tb_score_keeper_bcd : scoreboard bench for score_keeper_bcd (two configs)
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_score_keeper_bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] start_v;
    logic [1:0] over_v;
    logic [1:0] tick_v;

    logic [15:0] score_a, hiscore_a;
    logic        running_a, sat_a, mile_a, newhi_a;
    logic [7:0]  score_b, hiscore_b;
    logic        running_b, sat_b, mile_b, newhi_b;

    score_keeper_bcd #(.DIGITS(4), .TICKS_PER_POINT(6)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .game_start(start_v[0]), .game_over(over_v[0]), .game_tick(tick_v[0]),
        .score(score_a), .running(running_a), .saturated(sat_a),
        .milestone(mile_a), .hiscore(hiscore_a), .new_hiscore(newhi_a)
    );

    score_keeper_bcd #(.DIGITS(2), .TICKS_PER_POINT(1)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .game_start(start_v[1]), .game_over(over_v[1]), .game_tick(tick_v[1]),
        .score(score_b), .running(running_b), .saturated(sat_b),
        .milestone(mile_b), .hiscore(hiscore_b), .new_hiscore(newhi_b)
    );

    typedef enum int {
        SEL_SCORE, SEL_RUN, SEL_SAT, SEL_MILE, SEL_HI, SEL_NEWHI, SEL_MCNT,
        SEL_B_SCORE, SEL_B_SAT, SEL_B_RUN, SEL_B_MCNT
    } sel_e;

    typedef struct {
        string       name;
        sel_e        sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   checks     = 0;
    int   errors     = 0;
    int   mile_cnt_a = 0;
    int   mile_cnt_b = 0;

`ifdef SCORE_HISCORE_EN
    localparam logic [15:0] HI_G1 = 16'h0012;
    localparam logic [15:0] NH_G1 = 16'd1;
`else
    localparam logic [15:0] HI_G1 = 16'h0000;
    localparam logic [15:0] NH_G1 = 16'd0;
`endif

    function automatic logic [15:0] observe(sel_e s);
        case (s)
            SEL_SCORE:   return score_a;
            SEL_RUN:     return {15'd0, running_a};
            SEL_SAT:     return {15'd0, sat_a};
            SEL_MILE:    return {15'd0, mile_a};
            SEL_HI:      return hiscore_a;
            SEL_NEWHI:   return {15'd0, newhi_a};
            SEL_MCNT:    return 16'(mile_cnt_a);
            SEL_B_SCORE: return {8'd0, score_b};
            SEL_B_SAT:   return {15'd0, sat_b};
            SEL_B_RUN:   return {15'd0, running_b};
            SEL_B_MCNT:  return 16'(mile_cnt_b);
            default:     return 16'hxxxx;
        endcase
    endfunction

    // Monitor: samples on the falling edge and drains pending expectations.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        if (rst_n) begin
            if (mile_a) mile_cnt_a++;
            if (mile_b) mile_cnt_b++;
        end
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = observe(e.sel);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string n, input sel_e s, input logic [15:0] v);
        exp_t e;
        e.name = n;
        e.sel  = s;
        e.exp  = v;
        sbq.push_back(e);
    endtask

    task automatic settle();
        int k;
        k = 0;
        while (sbq.size() > 0 && k < 5) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic tick_n(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            tick_v[d] = 1'b1; step();
            tick_v[d] = 1'b0; step();
        end
    endtask

    task automatic start_p(input int d);
        start_v[d] = 1'b1; step();
        start_v[d] = 1'b0; step();
    endtask

    task automatic over_p(input int d);
        over_v[d] = 1'b1; step();
        over_v[d] = 1'b0; step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        start_v = 2'b00;
        over_v  = 2'b00;
        tick_v  = 2'b00;
        repeat (2) step();
        expect_v("reset_score",   SEL_SCORE,   16'h0000);
        expect_v("reset_running", SEL_RUN,     16'd0);
        expect_v("reset_sat",     SEL_SAT,     16'd0);
        expect_v("reset_mile",    SEL_MILE,    16'd0);
        expect_v("reset_hi",      SEL_HI,      16'h0000);
        expect_v("reset_newhi",   SEL_NEWHI,   16'd0);
        expect_v("reset_b_score", SEL_B_SCORE, 16'h0000);
        settle();
        rst_n = 1'b1;
        step();

        // Ticks before any start are ignored.
        tick_n(0, 3);
        tick_n(1, 3);
        expect_v("pre_start_score",   SEL_SCORE,   16'h0000);
        expect_v("pre_start_running", SEL_RUN,     16'd0);
        expect_v("pre_start_b_score", SEL_B_SCORE, 16'h0000);
        settle();

        start_p(0);
        expect_v("start_running", SEL_RUN,   16'd1);
        expect_v("start_score",   SEL_SCORE, 16'h0000);
        settle();

        tick_n(0, 60);
        expect_v("ticks60_score",   SEL_SCORE, 16'h0010);
        expect_v("ticks60_running", SEL_RUN,   16'd1);
        expect_v("ticks60_no_mile", SEL_MCNT,  16'd0);
        settle();

        // Held tick counts as a single event.
        tick_v[0] = 1'b1;
        repeat (20) step();
        tick_v[0] = 1'b0;
        step();
        tick_n(0, 4);
        expect_v("held_tick_score", SEL_SCORE, 16'h0010);
        settle();
        tick_n(0, 1);
        expect_v("held_tick_point", SEL_SCORE, 16'h0011);
        settle();

        tick_n(0, 3);
        start_p(0);
        expect_v("start_in_run_score",   SEL_SCORE, 16'h0011);
        expect_v("start_in_run_running", SEL_RUN,   16'd1);
        settle();
        tick_n(0, 3);
        expect_v("start_in_run_presc_kept", SEL_SCORE, 16'h0012);
        settle();

        start_p(1);
        tick_v[1] = 1'b1;
        repeat (20) step();
        tick_v[1] = 1'b0;
        step();
        expect_v("b_held_tick_score", SEL_B_SCORE, 16'h0001);
        settle();
        start_p(1);
        expect_v("b_start_in_run_score", SEL_B_SCORE, 16'h0001);
        expect_v("b_start_in_run_run",   SEL_B_RUN,   16'd1);
        settle();

        // Over and tick together: over wins, no point on the 6th tick.
        tick_n(0, 5);
        over_v[0] = 1'b1;
        tick_v[0] = 1'b1;
        step();
        expect_v("over_tick_running", SEL_RUN,   16'd0);
        expect_v("over_tick_score",   SEL_SCORE, 16'h0012);
        expect_v("game1_hiscore",     SEL_HI,    HI_G1);
        expect_v("game1_newhi",       SEL_NEWHI, NH_G1);
        settle();
        over_v[0] = 1'b0;
        tick_v[0] = 1'b0;
        step();
        tick_n(0, 10);
        expect_v("over_frozen_score", SEL_SCORE, 16'h0012);
        settle();

        start_v[0] = 1'b1;
        over_v[0]  = 1'b1;
        step();
        expect_v("restart_running", SEL_RUN,   16'd1);
        expect_v("restart_score",   SEL_SCORE, 16'h0000);
        expect_v("restart_newhi",   SEL_NEWHI, 16'd0);
        expect_v("restart_hi_kept", SEL_HI,    HI_G1);
        settle();
        start_v[0] = 1'b0;
        over_v[0]  = 1'b0;
        step();

        tick_n(0, 42);
        expect_v("game2_score", SEL_SCORE, 16'h0007);
        settle();
        over_p(0);
        expect_v("game2_running", SEL_RUN,   16'd0);
        expect_v("game2_hiscore", SEL_HI,    HI_G1);
        expect_v("game2_newhi",   SEL_NEWHI, 16'd0);
        settle();

        start_p(0);
        tick_n(0, 599);
        expect_v("pre_mile_score", SEL_SCORE, 16'h0099);
        expect_v("pre_mile_count", SEL_MCNT,  16'd0);
        settle();
        tick_v[0] = 1'b1;
        step();
        expect_v("mile_score", SEL_SCORE, 16'h0100);
        expect_v("mile_pulse", SEL_MILE,  16'd1);
        settle();
        tick_v[0] = 1'b0;
        step();
        expect_v("mile_drop",  SEL_MILE,  16'd0);
        expect_v("mile_count", SEL_MCNT,  16'd1);
        expect_v("mile_hold",  SEL_SCORE, 16'h0100);
        settle();

        tick_n(1, 104);
        expect_v("b_sat_score", SEL_B_SCORE, 16'h0099);
        expect_v("b_sat_flag",  SEL_B_SAT,   16'd1);
        expect_v("b_sat_nomile", SEL_B_MCNT, 16'd0);
        settle();
        tick_n(1, 3);
        expect_v("b_sat_hold_score", SEL_B_SCORE, 16'h0099);
        expect_v("b_sat_hold_flag",  SEL_B_SAT,   16'd1);
        settle();
        over_p(1);
        start_p(1);
        expect_v("b_restart_score", SEL_B_SCORE, 16'h0000);
        expect_v("b_restart_sat",   SEL_B_SAT,   16'd0);
        expect_v("b_restart_run",   SEL_B_RUN,   16'd1);
        settle();

        // Reset asserted between edges must act before the next rising edge.
        step();
        #2;
        rst_n = 1'b0;
        expect_v("async_rst_score",   SEL_SCORE,   16'h0000);
        expect_v("async_rst_running", SEL_RUN,     16'd0);
        expect_v("async_rst_hi",      SEL_HI,      16'h0000);
        expect_v("async_rst_newhi",   SEL_NEWHI,   16'd0);
        expect_v("async_rst_b_run",   SEL_B_RUN,   16'd0);
        settle();
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
